inert_sched: RTL and testbench



---
 rtl/inert_sched_pkg.sv | 51 +++++
 rtl/inert_sched_if.sv | 10 +
 rtl/inert_sched.sv | 137 +++++++++++++
 tb/tb_inert_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_sched_pkg.sv
// Shared definitions for the gyro SPI transaction sequencer: FSM states,
// SPI command words and small decode helpers.
package inert_pkg;

  typedef enum logic [3:0] {
    PWRUP    = 4'd0,
    CFG0_ISS = 4'd1,
    CFG0_WT  = 4'd2,
    CFG1_ISS = 4'd3,
    CFG1_WT  = 4'd4,
    CFG2_ISS = 4'd5,
    CFG2_WT  = 4'd6,
    WAIT_INT = 4'd7,
    RDL_ISS  = 4'd8,
    RDL_WT   = 4'd9,
    RDH_ISS  = 4'd10,
    RDH_WT   = 4'd11
  } state_t;

  // Bit 15 set marks a read; read data comes back in resp[7:0].
  localparam logic [15:0] CFG0    = 16'h0D02;  // INT on data ready
  localparam logic [15:0] CFG1    = 16'h1160;  // gyro 416 Hz, 250 dps
  localparam logic [15:0] CFG2    = 16'h1440;  // rounding on
  localparam logic [15:0] RD_YAWL = 16'hA600;
  localparam logic [15:0] RD_YAWH = 16'hA700;

  // True for the states that launch an SPI transaction.
  function automatic logic is_iss(input state_t s);
    logic r;
    case (s)
      CFG0_ISS, CFG1_ISS, CFG2_ISS, RDL_ISS, RDH_ISS: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Command word sent by each issue state.
  function automatic logic [15:0] iss_cmd(input state_t s);
    logic [15:0] c;
    case (s)
      CFG0_ISS: c = CFG0;
      CFG1_ISS: c = CFG1;
      CFG2_ISS: c = CFG2;
      RDL_ISS:  c = RD_YAWL;
      RDH_ISS:  c = RD_YAWH;
      default:  c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/inert_sched_if.sv
// Request/response link between the sequencer and the 16-bit SPI master.
interface inert_sched_if;
  logic        snd;   // one-cycle transaction start
  logic [15:0] cmd;   // command word, stable until done
  logic        done;  // transaction complete (stale high until after next snd)
  logic [15:0] resp;  // received word, valid while done is high

  modport master (output snd, output cmd, input done, input resp);
  modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/inert_sched.sv
// Gyro transaction sequencer: power-up delay, three configuration writes,
// then a low/high yaw-rate read pair on every data-ready interrupt.
module inert_sched
  import inert_pkg::*;
#(
  parameter int PWRUP_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  inert_sched_if.master      spi,
  output logic [15:0]        yaw_rt,
  output logic               vld,
  output logic               cfg_done
);

  localparam logic [PWRUP_W-1:0] CNT_ONE = PWRUP_W'(1);

  state_t              state_q, state_d;
  logic [PWRUP_W-1:0]  cnt_q, cnt_d;
  logic                int_s1_q, int_s2_q;
  logic                snd_q, snd_d;
  logic [15:0]         cmd_q, cmd_d;
  logic [15:0]         yaw_q, yaw_d;
  logic                vld_q, vld_d;
  logic                cfg_q, cfg_d;
  logic [7:0]          low_q, low_d;
  logic                resp_hi_unused;

  // Upper response byte carries nothing for the registers we read.
  assign resp_hi_unused = ^spi.resp[15:8];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWRUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done is only honoured in wait states, so the stale
  // done seen during an issue cycle cannot advance the sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PWRUP:    if (&cnt_q)      state_d = CFG0_ISS; else state_d = PWRUP;
      CFG0_ISS:                  state_d = CFG0_WT;
      CFG0_WT:  if (spi.done)    state_d = CFG1_ISS; else state_d = CFG0_WT;
      CFG1_ISS:                  state_d = CFG1_WT;
      CFG1_WT:  if (spi.done)    state_d = CFG2_ISS; else state_d = CFG1_WT;
      CFG2_ISS:                  state_d = CFG2_WT;
      CFG2_WT:  if (spi.done)    state_d = WAIT_INT; else state_d = CFG2_WT;
      WAIT_INT: if (int_s2_q)    state_d = RDL_ISS;  else state_d = WAIT_INT;
      RDL_ISS:                   state_d = RDL_WT;
      RDL_WT:   if (spi.done)    state_d = RDH_ISS;  else state_d = RDL_WT;
      RDH_ISS:                   state_d = RDH_WT;
      RDH_WT:   if (spi.done)    state_d = WAIT_INT; else state_d = RDH_WT;
      default:                   state_d = PWRUP;
    endcase
  end

  // Output/datapath next values; snd and cmd are loaded on entry to an
  // issue state so the registered strobe coincides with that state.
  always_comb begin
    snd_d = 1'b0;
    cmd_d = cmd_q;
    yaw_d = yaw_q;
    vld_d = 1'b0;
    cfg_d = cfg_q;
    low_d = low_q;
    cnt_d = cnt_q;
    if (is_iss(state_d)) begin
      snd_d = 1'b1;
      cmd_d = iss_cmd(state_d);
    end else begin
      snd_d = 1'b0;
    end
    case (state_q)
      PWRUP: begin
        if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
        else           cnt_d = cnt_q;
      end
      CFG2_WT: begin
        if (spi.done) cfg_d = 1'b1;
        else          cfg_d = cfg_q;
      end
      RDL_WT: begin
        if (spi.done) low_d = spi.resp[7:0];
        else          low_d = low_q;
      end
      RDH_WT: begin
        if (spi.done) begin
          yaw_d = {spi.resp[7:0], low_q};
          vld_d = 1'b1;
        end else begin
          vld_d = 1'b0;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output, datapath and INT synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      int_s1_q <= 1'b0;
      int_s2_q <= 1'b0;
      snd_q    <= 1'b0;
      cmd_q    <= 16'h0000;
      yaw_q    <= 16'h0000;
      vld_q    <= 1'b0;
      cfg_q    <= 1'b0;
      low_q    <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      int_s1_q <= INT;
      int_s2_q <= int_s1_q;
      snd_q    <= snd_d;
      cmd_q    <= cmd_d;
      yaw_q    <= yaw_d;
      vld_q    <= vld_d;
      cfg_q    <= cfg_d;
      low_q    <= low_d;
    end
  end

  assign spi.snd  = snd_q;
  assign spi.cmd  = cmd_q;
  assign yaw_rt   = yaw_q;
  assign vld      = vld_q;
  assign cfg_done = cfg_q;

endmodule

// File: tb/tb_inert_sched.sv
// Bench for inert_sched: behavioural SPI master + sensor model, a
// transaction log, and an expected-yaw scoreboard.
module tb_inert_sched;
  import inert_pkg::*;

  typedef struct { logic [7:0] lo; logic [7:0] hi; logic [15:0] yaw; } vec_t;
  typedef struct { logic [15:0] cmd; logic cfg; int cyc; } snd_rec_t;
  typedef struct { logic [7:0] lo; logic [7:0] hi; } pair_t;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        cfg_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int rel_cyc = 0;

  snd_rec_t    log_q[$];
  pair_t       pair_q[$];
  logic [15:0] exp_q[$];

  inert_sched_if spi();

  inert_sched #(.PWRUP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .spi(spi),
    .yaw_rt(yaw_rt), .vld(vld), .cfg_done(cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // Boot sequence: power-up delay of 16 clocks, then three config writes.
  task automatic boot_check(input int int_at);
    logic [15:0] boot_cmds[3];
    boot_cmds[0] = 16'h0D02;
    boot_cmds[1] = 16'h1160;
    boot_cmds[2] = 16'h1440;
    for (int n = 1; n <= 300 && !cfg_done; n++) begin
      tick();
      if (n == int_at) INT = 1'b1;
    end
    chk("cfg_done_rise", 32'(cfg_done), 32'd1);
    chk("boot_snd_cnt", 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      chk("cfg0_delay", 32'(log_q[0].cyc - rel_cyc), 32'd17);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cfg%0d_cmd", i), 32'(log_q[i].cmd), 32'(boot_cmds[i]));
        chk($sformatf("cfg%0d_pre_done", i), 32'(log_q[i].cfg), 32'd0);
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic push_pair(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] yaw);
    pair_q.push_back('{lo: lo, hi: hi});
    exp_q.push_back(yaw);
  endtask

  // Monitor: logs every snd, checks strobe widths, yaw values and yaw hold.
  initial begin : mon
    logic p_snd, p_vld, p_rst;
    logic [15:0] p_yaw, e;
    p_snd = 1'b0; p_vld = 1'b0; p_rst = 1'b0; p_yaw = 16'h0000;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (spi.snd) begin
        log_q.push_back('{cmd: spi.cmd, cfg: cfg_done, cyc: cyc});
        chk("snd_one_cycle", 32'(p_snd), 32'd0);
      end
      if (vld) begin
        vld_cnt++;
        chk("vld_width_mon", 32'(p_vld), 32'd0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~yaw_rt;
        chk("yaw_value", 32'(yaw_rt), 32'(e));
      end else if (rst_n && p_rst) begin
        chk("yaw_hold", 32'(yaw_rt), 32'(p_yaw));
      end
      p_snd = spi.snd; p_vld = vld; p_rst = rst_n; p_yaw = yaw_rt;
    end
  end

  // SPI master + sensor: done low the cycle after snd, high again after a
  // random latency; the sensor drops INT when its last sample's high byte is read.
  initial begin : spi_model
    logic [15:0] c;
    logic [7:0]  rb;
    int          lat;
    spi.done = 1'b0;
    spi.resp = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi.snd && rst_n) begin
        c   = spi.cmd;
        lat = $urandom_range(2, 6);
        rb  = 8'($urandom);
        if (c == 16'hA600) begin
          if (pair_q.size() != 0) rb = pair_q[0].lo;
        end else if (c == 16'hA700) begin
          if (pair_q.size() != 0) rb = pair_q.pop_front().hi;
          if (pair_q.size() == 0) INT = 1'b0;
        end
        @(negedge clk);
        spi.done = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!rst_n) break;
        end
        if (rst_n) begin
          chk("cmd_stable", 32'(spi.cmd), 32'(c));
          spi.resp = {8'($urandom), rb};
          spi.done = 1'b1;
          if (c == 16'hA700) begin
            fork
              begin
                @(negedge clk); #1;
                chk("vld_on_time", 32'(vld), 32'd1);
                @(negedge clk); #1;
                chk("vld_one_cycle", 32'(vld), 32'd0);
              end
            join_none
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[3];
    int   sz, vc, nb;
    logic [7:0] lo, hi;
    tbl[0] = '{lo: 8'h34, hi: 8'h12, yaw: 16'h1234};
    tbl[1] = '{lo: 8'hFF, hi: 8'h80, yaw: 16'h80FF};
    tbl[2] = '{lo: 8'h01, hi: 8'h00, yaw: 16'h0001};

    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (3) tick();
    chk("rst_snd", 32'(spi.snd), 32'd0);
    chk("rst_cmd", 32'(spi.cmd), 32'h0000);
    chk("rst_yaw", 32'(yaw_rt), 32'h0000);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);

    // Boot with INT raised early: the read waits for configuration.
    push_pair(tbl[0].lo, tbl[0].hi, tbl[0].yaw);
    release_rst();
    boot_check(5);
    drain("pair0_drain", 200);
    chk("rd_cnt", 32'(log_q.size()), 32'd5);
    if (log_q.size() >= 5) begin
      chk("rdl_cmd", 32'(log_q[3].cmd), 32'hA600);
      chk("rdl_after_cfg", 32'(log_q[3].cfg), 32'd1);
      chk("rdh_cmd", 32'(log_q[4].cmd), 32'hA700);
    end
    sz = log_q.size();
    repeat (100) tick();
    chk("yaw_hold_100", 32'(yaw_rt), 32'(tbl[0].yaw));
    chk("idle_no_snd", 32'(log_q.size()), 32'(sz));

    // INT held across back-to-back read pairs from the table.
    for (int i = 1; i < 3; i++) push_pair(tbl[i].lo, tbl[i].hi, tbl[i].yaw);
    INT = 1'b1;
    drain("burst_drain", 300);
    chk("burst_last_yaw", 32'(yaw_rt), 32'(tbl[2].yaw));
    chk("burst_snd_cnt", 32'(log_q.size() - sz), 32'd4);

    // Random bursts of 1..3 samples.
    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        lo = 8'($urandom);
        hi = 8'($urandom);
        push_pair(lo, hi, {hi, lo});
      end
      repeat ($urandom_range(0, 5)) tick();
      INT = 1'b1;
      drain($sformatf("rand%0d_drain", r), 400);
    end

    // Spurious done activity while idle in WAIT_INT.
    INT = 1'b0;
    repeat (4) tick();
    sz = log_q.size();
    vc = vld_cnt;
    for (int n = 0; n < 8; n++) begin
      tick();
      spi.done = ~spi.done;
    end
    spi.done = 1'b1;
    repeat (5) tick();
    chk("spur_no_snd", 32'(log_q.size()), 32'(sz));
    chk("spur_no_vld", 32'(vld_cnt), 32'(vc));
    chk("spur_cfg_done", 32'(cfg_done), 32'd1);

    // Reset while waiting for the high-byte read.
    pair_q.push_back('{lo: 8'h55, hi: 8'h66});
    INT = 1'b1;
    for (int n = 0; n < 200 && !(log_q.size() > sz && log_q[$].cmd == 16'hA700); n++) tick();
    chk("rdh_seen", 32'(log_q[$].cmd), 32'hA700);
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pair_q.delete();
    INT = 1'b0;
    vc = vld_cnt;
    repeat (3) tick();
    chk("mid_rst_yaw", 32'(yaw_rt), 32'h0000);
    chk("mid_rst_cfg", 32'(cfg_done), 32'd0);
    chk("mid_rst_snd", 32'(spi.snd), 32'd0);
    log_q.delete();
    release_rst();
    tick();
    chk("rel_yaw", 32'(yaw_rt), 32'h0000);
    chk("rel_cfg", 32'(cfg_done), 32'd0);
    boot_check(0);
    repeat (10) tick();
    chk("rst_no_vld", 32'(vld_cnt), 32'(vc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
